cpu_run_ctrl: RTL and testbench
===============================

CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: resetn  in  1  synchronous, active-low reset.
REQ-003 SHALL have port: start  in  1  pulse; restart program from PC 0.
REQ-004 SHALL have port: resume  in  1  pulse; continue from HALTED without CPU reset.
REQ-005 SHALL have port: step  in  1  pulse; execute exactly one instruction from HALTED.
REQ-006 SHALL have port: halt_req  in  1  level; external stop request.
REQ-007 SHALL have port: bp_en  in  1  breakpoint enable.
REQ-008 SHALL have port: bp_addr  in  10  breakpoint PC.
REQ-009 SHALL have port: cycle_limit  in  16  max retired instructions per run; 0 = unlimited.
REQ-010 SHALL have port: pc  in  10  current PC from datapath.
REQ-011 SHALL have port: instruction  in  16  current instruction word.
REQ-012 SHALL have port: cpu_en  out  1  datapath clock-enable; one instruction retires per cycle with cpu_en=1.
REQ-013 SHALL have port: cpu_resetn  out  1  active-low reset to datapath.
REQ-014 SHALL have port: state  out  3  current FSM state encoding.
REQ-015 SHALL have port: halt_cause  out  3  reason for last halt.
REQ-016 SHALL have port: retired  out  16  instructions retired since last start.

Function
REQ-017 States: IDLE, CPURST, RUN, STEP, HALTED.
REQ-018 IDLE: cpu_en=0, cpu_resetn=0; start -> CPURST.
REQ-019 CPURST: cpu_resetn=0 for exactly RST_HOLD=2 cycles, retired cleared to 0; then -> RUN.
REQ-020 RUN: cpu_en=1 unless a stop condition is true this cycle; a stopped instruction does not retire.
REQ-021 Stop conditions, evaluated combinationally on pc/instruction, priority high->low: HALT_INSN (instruction[15:12]==4'hF) > BREAK (bp_en && pc==bp_addr && !bp_skip) > EXT (halt_req) > LIMIT (cycle_limit!=0 && retired==cycle_limit).
REQ-022 Any stop condition in RUN -> HALTED next cycle; halt_cause latches highest-priority cause.
REQ-023 HALTED: cpu_en=0, cpu_resetn=1; start -> CPURST; step -> STEP; resume -> RUN; simultaneous pulses priority start > step > resume.
REQ-024 STEP: cpu_en=1 for exactly one cycle, unless instruction is HALT_INSN (cpu_en=0); then -> HALTED, cause STEP (or HALT_INSN).
REQ-025 bp_skip set on leaving HALTED via resume or step, cleared after first retired instruction; permits continuing past the breakpoint.
REQ-026 step and resume while HALT_INSN is current: stay HALTED, cause HALT_INSN unchanged.
REQ-027 start, step, resume ignored in RUN, STEP, CPURST; start in IDLE or HALTED only.
REQ-028 retired increments by 1 each cycle cpu_en=1; saturates at 16'hFFFF; no wrap.
REQ-029 halt_cause encoding: NONE=0, HALT_INSN=1, BREAK=2, EXT=3, LIMIT=4, STEP=5; cleared to NONE on entry to CPURST.
REQ-030 halt_req held in HALTED does not block step or resume; it re-halts at the next RUN cycle (cause EXT) after the bp_skip cycle retires.

Reset
REQ-031 resetn=0 at any clk edge, including mid-RUN/STEP: state=IDLE, cpu_en=0, cpu_resetn=0, halt_cause=NONE, retired=0, bp_skip=0, RST_HOLD count=0.
REQ-032 No output SHALL depend on resetn asynchronously.

Structure
REQ-033 Package cpu_ctrl_pkg SHALL hold the state enum, halt_cause enum, HALT_OPCODE=4'hF, RST_HOLD=2.
REQ-034 One sub-module retire_counter (16-bit saturating counter, sync clear, enable) SHALL implement retired.

Verification
REQ-035 reset, start -> cpu_resetn low exactly 2 cycles, then cpu_en=1, state=RUN, retired counts 1,2,3...
REQ-036 bp_en=1, bp_addr=10'd5, run to pc=5 -> cpu_en=0 that cycle, HALTED, halt_cause=2; resume -> pc 5 retires, no re-halt.
REQ-037 instruction=16'hF000 at pc=7 in RUN -> HALTED, halt_cause=1, retired unchanged; step -> stays HALTED.
REQ-038 HALTED, step pulse -> exactly one cpu_en=1 cycle, retired+1, halt_cause=5.
REQ-039 cycle_limit=16'd3 -> exactly 3 retirements, then HALTED, halt_cause=4; start, step and resume same cycle -> CPURST.
REQ-040 resetn=0 mid-RUN -> next edge state=IDLE, cpu_en=0, retired=0, halt_cause=0.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the CPU run controller.
// Holds the state and halt-cause encodings that appear on the debug outputs.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CPURST = 3'd1,
        ST_RUN    = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALTED = 3'd4
    } run_state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE      = 3'd0,
        CAUSE_HALT_INSN = 3'd1,
        CAUSE_BREAK     = 3'd2,
        CAUSE_EXT       = 3'd3,
        CAUSE_LIMIT     = 3'd4,
        CAUSE_STEP      = 3'd5
    } halt_cause_e;

    localparam logic [3:0] HALT_OPCODE = 4'hF;
    localparam int         RST_HOLD    = 2;

    function automatic logic is_halt_insn(input logic [15:0] insn);
        return insn[15:12] == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/retire_counter.sv
// 16-bit retired-instruction counter: synchronous clear, enable, saturates at all-ones.
module retire_counter
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] count
);

    logic [15:0] count_q;
    logic [15:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 16'd0;
        end else if (en && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            count_q <= 16'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step controller gating a single-cycle CPU datapath.
// cpu_en is combinational from state and the current pc/instruction so a stopping instruction never retires.
module cpu_run_ctrl
    import cpu_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        resume,
    input  logic        step,
    input  logic        halt_req,
    input  logic        bp_en,
    input  logic [9:0]  bp_addr,
    input  logic [15:0] cycle_limit,
    input  logic [9:0]  pc,
    input  logic [15:0] instruction,
    output logic        cpu_en,
    output logic        cpu_resetn,
    output logic [2:0]  state,
    output logic [2:0]  halt_cause,
    output logic [15:0] retired
);

    localparam logic [1:0] RST_LAST = 2'(RST_HOLD - 1);

    run_state_e  state_q, state_d;
    halt_cause_e cause_q, cause_d;
    logic        bp_skip_q, bp_skip_d;
    logic [1:0]  rst_cnt_q, rst_cnt_d;
    logic        cnt_clr;

    logic        stop_insn, stop_brk, stop_ext, stop_lim, stop_any;
    halt_cause_e stop_cause;

    // bp_skip masks the breakpoint and the external request for the first
    // instruction after leaving HALTED, so execution can move past either.
    always_comb begin
        stop_insn = is_halt_insn(instruction);
        stop_brk  = bp_en && (pc == bp_addr) && !bp_skip_q;
        stop_ext  = halt_req && !bp_skip_q;
        stop_lim  = (cycle_limit != 16'd0) && (retired == cycle_limit);
        stop_any  = stop_insn || stop_brk || stop_ext || stop_lim;

        stop_cause = CAUSE_NONE;
        if (stop_insn) begin
            stop_cause = CAUSE_HALT_INSN;
        end else if (stop_brk) begin
            stop_cause = CAUSE_BREAK;
        end else if (stop_ext) begin
            stop_cause = CAUSE_EXT;
        end else if (stop_lim) begin
            stop_cause = CAUSE_LIMIT;
        end
    end

    always_comb begin
        state_d    = state_q;
        cause_d    = cause_q;
        bp_skip_d  = bp_skip_q;
        rst_cnt_d  = rst_cnt_q;
        cpu_en     = 1'b0;
        cpu_resetn = 1'b1;
        cnt_clr    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cpu_resetn = 1'b0;
                if (start) begin
                    state_d   = ST_CPURST;
                    rst_cnt_d = 2'd0;
                    cause_d   = CAUSE_NONE;
                end
            end

            ST_CPURST: begin
                cpu_resetn = 1'b0;
                cnt_clr    = 1'b1;
                bp_skip_d  = 1'b0;
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = ST_RUN;
                    rst_cnt_d = 2'd0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 2'd1;
                end
            end

            ST_RUN: begin
                if (stop_any) begin
                    state_d = ST_HALTED;
                    cause_d = stop_cause;
                end else begin
                    cpu_en    = 1'b1;
                    bp_skip_d = 1'b0;
                end
            end

            ST_STEP: begin
                state_d = ST_HALTED;
                if (stop_insn) begin
                    cause_d = CAUSE_HALT_INSN;
                end else begin
                    cpu_en    = 1'b1;
                    bp_skip_d = 1'b0;
                    cause_d   = CAUSE_STEP;
                end
            end

            ST_HALTED: begin
                if (start) begin
                    state_d   = ST_CPURST;
                    rst_cnt_d = 2'd0;
                    cause_d   = CAUSE_NONE;
                end else if ((step || resume) && !stop_insn) begin
                    // A halt instruction keeps the core parked until a fresh start.
                    state_d   = step ? ST_STEP : ST_RUN;
                    bp_skip_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cause_q   <= CAUSE_NONE;
            bp_skip_q <= 1'b0;
            rst_cnt_q <= 2'd0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            bp_skip_q <= bp_skip_d;
            rst_cnt_q <= rst_cnt_d;
        end
    end

    retire_counter u_retire_counter (
        .clk    (clk),
        .resetn (resetn),
        .clr    (cnt_clr),
        .en     (cpu_en),
        .count  (retired)
    );

    assign state      = state_q;
    assign halt_cause = cause_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with a tiny datapath model: pc advances on cpu_en, clears on cpu_resetn low.
module tb_cpu_run_ctrl;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        resume = 1'b0;
    logic        step = 1'b0;
    logic        halt_req = 1'b0;
    logic        bp_en = 1'b0;
    logic [9:0]  bp_addr = 10'd0;
    logic [15:0] cycle_limit = 16'd0;
    logic [9:0]  pc = 10'd0;
    logic [15:0] instruction = 16'h0000;
    logic        cpu_en;
    logic        cpu_resetn;
    logic [2:0]  state;
    logic [2:0]  halt_cause;
    logic [15:0] retired;

    int n_tests = 0;
    int n_fail  = 0;

    cpu_run_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .resume      (resume),
        .step        (step),
        .halt_req    (halt_req),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .cycle_limit (cycle_limit),
        .pc          (pc),
        .instruction (instruction),
        .cpu_en      (cpu_en),
        .cpu_resetn  (cpu_resetn),
        .state       (state),
        .halt_cause  (halt_cause),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock: datapath model updates from values held before the edge,
    // then inputs settle so outputs are sampled 2 time units after the edge.
    task automatic tick();
        logic en_s;
        logic rn_s;
        en_s = cpu_en;
        rn_s = cpu_resetn;
        @(posedge clk);
        #1;
        if (rn_s === 1'b0) begin
            pc = 10'd0;
        end else if (en_s === 1'b1) begin
            pc = pc + 10'd1;
        end
        instruction = (pc == 10'd7) ? 16'hF000 : 16'h0000;
        #1;
    endtask

    task automatic pulse(input logic s, input logic st, input logic r);
        start  = s;
        step   = st;
        resume = r;
        tick();
        start  = 1'b0;
        step   = 1'b0;
        resume = 1'b0;
        #1;
    endtask

    initial begin
        // Reset state
        resetn = 1'b0;
        tick();
        tick();
        check("rst_state", {29'd0, state}, 32'd0);
        check("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("rst_cpu_resetn", {31'd0, cpu_resetn}, 32'd0);
        check("rst_cause", {29'd0, halt_cause}, 32'd0);
        check("rst_retired", {16'd0, retired}, 32'd0);
        resetn = 1'b1;
        tick();
        check("idle_hold", {29'd0, state}, 32'd0);

        // Start: two cycles of datapath reset, then RUN counting 1,2,3
        bp_en   = 1'b1;
        bp_addr = 10'd5;
        pulse(1'b1, 1'b0, 1'b0);
        check("cpurst_state", {29'd0, state}, 32'd1);
        check("cpurst_rstn_c1", {31'd0, cpu_resetn}, 32'd0);
        tick();
        check("cpurst_rstn_c2", {31'd0, cpu_resetn}, 32'd0);
        check("cpurst_state_c2", {29'd0, state}, 32'd1);
        tick();
        check("run_state", {29'd0, state}, 32'd2);
        check("run_rstn", {31'd0, cpu_resetn}, 32'd1);
        check("run_cpu_en", {31'd0, cpu_en}, 32'd1);
        check("run_retired0", {16'd0, retired}, 32'd0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("run_retired_n", {16'd0, retired}, 32'(i));
        end

        // Breakpoint at pc 5
        tick();
        tick();
        check("bp_pc", {22'd0, pc}, 32'd5);
        check("bp_cpu_en", {31'd0, cpu_en}, 32'd0);
        tick();
        check("bp_state", {29'd0, state}, 32'd4);
        check("bp_cause", {29'd0, halt_cause}, 32'd2);
        check("bp_retired", {16'd0, retired}, 32'd5);
        pulse(1'b0, 1'b0, 1'b1);
        check("bp_resume_en", {31'd0, cpu_en}, 32'd1);
        tick();
        check("bp_past_pc", {22'd0, pc}, 32'd6);
        check("bp_past_retired", {16'd0, retired}, 32'd6);
        check("bp_past_state", {29'd0, state}, 32'd2);

        // Halt instruction at pc 7
        tick();
        check("hi_pc", {22'd0, pc}, 32'd7);
        check("hi_cpu_en", {31'd0, cpu_en}, 32'd0);
        tick();
        check("hi_state", {29'd0, state}, 32'd4);
        check("hi_cause", {29'd0, halt_cause}, 32'd1);
        check("hi_retired", {16'd0, retired}, 32'd7);
        pulse(1'b0, 1'b1, 1'b0);
        check("hi_step_state", {29'd0, state}, 32'd4);
        check("hi_step_cause", {29'd0, halt_cause}, 32'd1);
        check("hi_step_retired", {16'd0, retired}, 32'd7);
        pulse(1'b0, 1'b0, 1'b1);
        check("hi_resume_state", {29'd0, state}, 32'd4);

        // Restart, external halt, single step, resume with halt_req held
        pulse(1'b1, 1'b0, 1'b0);
        check("restart_state", {29'd0, state}, 32'd1);
        check("restart_cause", {29'd0, halt_cause}, 32'd0);
        tick();
        tick();
        check("restart_retired", {16'd0, retired}, 32'd0);
        tick();
        halt_req = 1'b1;
        #1;
        check("ext_cpu_en", {31'd0, cpu_en}, 32'd0);
        tick();
        check("ext_state", {29'd0, state}, 32'd4);
        check("ext_cause", {29'd0, halt_cause}, 32'd3);
        check("ext_retired", {16'd0, retired}, 32'd1);
        pulse(1'b0, 1'b1, 1'b0);
        check("step_state", {29'd0, state}, 32'd3);
        check("step_cpu_en", {31'd0, cpu_en}, 32'd1);
        tick();
        check("step_done_state", {29'd0, state}, 32'd4);
        check("step_cpu_en_off", {31'd0, cpu_en}, 32'd0);
        check("step_cause", {29'd0, halt_cause}, 32'd5);
        check("step_retired", {16'd0, retired}, 32'd2);
        pulse(1'b0, 1'b0, 1'b1);
        check("ext_resume_en", {31'd0, cpu_en}, 32'd1);
        tick();
        check("ext_rehalt_retired", {16'd0, retired}, 32'd3);
        check("ext_rehalt_en", {31'd0, cpu_en}, 32'd0);
        tick();
        check("ext_rehalt_cause", {29'd0, halt_cause}, 32'd3);
        halt_req = 1'b0;

        // Cycle limit 3; simultaneous start/step/resume picks start
        cycle_limit = 16'd3;
        pulse(1'b1, 1'b1, 1'b1);
        check("prio_state", {29'd0, state}, 32'd1);
        check("prio_cause", {29'd0, halt_cause}, 32'd0);
        tick();
        tick();
        tick();
        tick();
        tick();
        check("lim_retired", {16'd0, retired}, 32'd3);
        check("lim_cpu_en", {31'd0, cpu_en}, 32'd0);
        tick();
        check("lim_state", {29'd0, state}, 32'd4);
        check("lim_cause", {29'd0, halt_cause}, 32'd4);
        check("lim_retired_hold", {16'd0, retired}, 32'd3);

        // Start ignored in RUN, then reset mid-RUN
        cycle_limit = 16'd0;
        bp_en       = 1'b0;
        pulse(1'b0, 1'b0, 1'b1);
        check("run2_cpu_en", {31'd0, cpu_en}, 32'd1);
        pulse(1'b1, 1'b0, 1'b0);
        check("run_start_ign", {29'd0, state}, 32'd2);
        check("run_start_ret", {16'd0, retired}, 32'd4);
        resetn = 1'b0;
        tick();
        check("midrst_state", {29'd0, state}, 32'd0);
        check("midrst_cpu_en", {31'd0, cpu_en}, 32'd0);
        check("midrst_rstn", {31'd0, cpu_resetn}, 32'd0);
        check("midrst_retired", {16'd0, retired}, 32'd0);
        check("midrst_cause", {29'd0, halt_cause}, 32'd0);
        resetn = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
